// File: rtl/cache_fill_arbiter_pkg.sv
// Shared types and constants for the cache fill arbiter.
// No logic; pure declarations.
// No flow control.
package mem_arb_pkg;

  // Words per 16-byte block and the width of a word index within it.
  localparam int WORDS_PER_BLOCK = 8;
  localparam int CNT_W           = 3;

  // Clears the byte offset within a 16-byte block.
  localparam logic [15:0] BLOCK_MASK = 16'hFFF0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STORE = 2'd1,
    FILL  = 2'd2
  } state_t;

  typedef enum logic {
    TGT_I = 1'b0,
    TGT_D = 1'b1
  } target_t;

endpackage

// File: rtl/cache_fill_arbiter_if.sv
// Port bundle between the arbiter and the shared pipelined main memory.
// Memory returns read data a fixed 4 cycles after the read is issued.
// No backpressure: memory accepts one access per cycle unconditionally.
interface cache_fill_arbiter_if #(
  parameter int ADDR_W = 16
) ();

  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic              mem_valid;

  // Arbiter side issues accesses and receives read returns.
  modport master (
    output mem_en, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata, mem_valid
  );

  // Memory side.
  modport slave (
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    output mem_rdata, mem_valid
  );

endinterface

// File: rtl/cache_fill_arbiter_word_counter.sv
// Word index counter for block fills, with synchronous clear and increment.
// Count updates one cycle after inc; done is combinational (count==max and inc).
// No backpressure: inc is applied whenever asserted.
module word_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         done
);

  // Clear takes priority over increment; wraps to zero after the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

  assign done = inc && (count == {W{1'b1}});

endmodule

// File: rtl/cache_fill_arbiter.sv
// Shares one pipelined memory between I/D block fills and D write-through stores.
// Fill: reads in cycles 1-8 after the request, tag write in cycle 12; store: 1 cycle.
// Requests are level-held and wait in IDLE; stores win over misses, I over D.
module cache_fill_arbiter #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_miss,
  input  logic [ADDR_W-1:0]     i_miss_addr,
  input  logic                  d_miss,
  input  logic [ADDR_W-1:0]     d_miss_addr,
  input  logic                  d_store,
  input  logic [ADDR_W-1:0]     d_store_addr,
  input  logic [15:0]           d_store_data,
  output logic                  store_ack,
  cache_fill_arbiter_if.master  mem,
  output logic [ADDR_W-1:0]     fill_addr,
  output logic [15:0]           fill_data,
  output logic                  i_data_we,
  output logic                  d_data_we,
  output logic                  i_tag_we,
  output logic                  d_tag_we,
  output logic                  busy
);

  import mem_arb_pkg::*;

  localparam int CW = $clog2(WORDS_PER_BLOCK);

  state_t            state;
  state_t            state_nxt;
  target_t           tgt;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] st_addr;
  logic [15:0]       st_data;
  logic              issuing;

  logic [CW-1:0]     issue_cnt;
  logic [CW-1:0]     ret_cnt;
  logic              issue_done;
  logic              ret_done;
  logic              issue_inc;
  logic              ret_inc;
  logic              take_store;
  logic              take_miss;

  // Arbitration decisions are only made in IDLE.
  assign take_store = (state == IDLE) && d_store;
  assign take_miss  = (state == IDLE) && !d_store && (i_miss || d_miss);

  // Read returns outside FILL are ignored entirely.
  assign issue_inc = (state == FILL) && issuing;
  assign ret_inc   = (state == FILL) && mem.mem_valid;

  word_counter #(.W(CW)) u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (take_miss),
    .inc   (issue_inc),
    .count (issue_cnt),
    .done  (issue_done)
  );

  word_counter #(.W(CW)) u_ret_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (take_miss),
    .inc   (ret_inc),
    .count (ret_cnt),
    .done  (ret_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: a store takes one cycle, a fill ends on its last return.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (d_store) begin
          state_nxt = STORE;
        end else if (i_miss || d_miss) begin
          state_nxt = FILL;
        end
      end
      STORE:   state_nxt = IDLE;
      FILL:    state_nxt = ret_done ? IDLE : FILL;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture request context when granted so outputs never depend on live inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt     <= TGT_I;
      base    <= '0;
      st_addr <= '0;
      st_data <= '0;
      issuing <= 1'b0;
    end else begin
      if (take_store) begin
        st_addr <= d_store_addr;
        st_data <= d_store_data;
      end
      if (take_miss) begin
        tgt     <= i_miss ? TGT_I : TGT_D;
        base    <= (i_miss ? i_miss_addr : d_miss_addr) & ADDR_W'(BLOCK_MASK);
        issuing <= 1'b1;
      end else if (issue_done) begin
        issuing <= 1'b0;
      end
    end
  end

  // Outputs from registered state; only read-return strobes follow mem_valid.
  always_comb begin
    mem.mem_en    = 1'b0;
    mem.mem_wr    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    store_ack     = 1'b0;
    fill_addr     = '0;
    i_data_we     = 1'b0;
    d_data_we     = 1'b0;
    i_tag_we      = 1'b0;
    d_tag_we      = 1'b0;
    case (state)
      STORE: begin
        mem.mem_en    = 1'b1;
        mem.mem_wr    = 1'b1;
        mem.mem_addr  = st_addr;
        mem.mem_wdata = st_data;
        store_ack     = 1'b1;
      end
      FILL: begin
        if (issuing) begin
          mem.mem_en   = 1'b1;
          mem.mem_addr = base + ADDR_W'({issue_cnt, 1'b0});
        end
        fill_addr = base + ADDR_W'({ret_cnt, 1'b0});
        i_data_we = mem.mem_valid && (tgt == TGT_I);
        d_data_we = mem.mem_valid && (tgt == TGT_D);
        i_tag_we  = ret_done && (tgt == TGT_I);
        d_tag_we  = ret_done && (tgt == TGT_D);
      end
      default: ;
    endcase
  end

  assign fill_data = mem.mem_rdata;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Bench for cache_fill_arbiter: directed requests, a 4-cycle memory model and a
// per-cycle timeline model of the expected outputs, plus literal spot checks.
// Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
module tb_cache_fill_arbiter;

  localparam int NCYC = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_miss, d_miss, d_store;
  logic [15:0] i_miss_addr, d_miss_addr, d_store_addr, d_store_data;
  logic        store_ack, i_data_we, d_data_we, i_tag_we, d_tag_we, busy;
  logic [15:0] fill_addr, fill_data;
  logic        inject;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int free_at  = 0;

  cache_fill_arbiter_if #(.ADDR_W(16)) mif ();

  cache_fill_arbiter #(.WORDS_PER_BLOCK(8), .ADDR_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_miss       (i_miss),
    .i_miss_addr  (i_miss_addr),
    .d_miss       (d_miss),
    .d_miss_addr  (d_miss_addr),
    .d_store      (d_store),
    .d_store_addr (d_store_addr),
    .d_store_data (d_store_data),
    .store_ack    (store_ack),
    .mem          (mif),
    .fill_addr    (fill_addr),
    .fill_data    (fill_data),
    .i_data_we    (i_data_we),
    .d_data_we    (d_data_we),
    .i_tag_we     (i_tag_we),
    .d_tag_we     (d_tag_we),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Memory: a read issued in cycle c returns addr^5A3C in cycle c+4.
  logic        rq;
  logic [15:0] ra;
  logic        pv [4];
  logic [15:0] pa [4];

  always @(negedge clk) begin
    rq <= mif.mem_en & ~mif.mem_wr;
    ra <= mif.mem_addr;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        pv[i] <= 1'b0;
        pa[i] <= 16'h0;
      end
    end else begin
      pv[0] <= rq;
      pa[0] <= ra;
      for (int i = 1; i < 4; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end
    end
  end

  assign mif.mem_valid = pv[3] | inject;
  assign mif.mem_rdata = pv[3] ? (pa[3] ^ 16'h5A3C) : (inject ? 16'hDEAD : 16'h0);

  // Expected-output timeline, indexed by cycle number.
  bit        e_en   [NCYC];
  bit        e_wr   [NCYC];
  bit [15:0] e_addr [NCYC];
  bit [15:0] e_wdat [NCYC];
  bit        e_ack  [NCYC];
  bit        e_busy [NCYC];
  bit        e_iwe  [NCYC];
  bit        e_dwe  [NCYC];
  bit        e_itag [NCYC];
  bit        e_dtag [NCYC];
  bit [15:0] e_fadr [NCYC];

  task automatic sched_store(input int t, input logic [15:0] a, input logic [15:0] d);
    if (t + 1 < NCYC) begin
      e_en[t+1]   = 1'b1;
      e_wr[t+1]   = 1'b1;
      e_addr[t+1] = a;
      e_wdat[t+1] = d;
      e_ack[t+1]  = 1'b1;
      e_busy[t+1] = 1'b1;
    end
    free_at = t + 2;
  endtask

  // A fill granted at cycle t: word k read at t+1+k, returned at t+5+k.
  task automatic sched_fill(input int t, input bit is_d, input logic [15:0] a);
    logic [15:0] b;
    b = a & 16'hFFF0;
    if (t + 13 < NCYC) begin
      for (int k = 0; k < 8; k++) begin
        e_en[t+1+k]   = 1'b1;
        e_addr[t+1+k] = b + 16'(2 * k);
        e_fadr[t+5+k] = b + 16'(2 * k);
        if (is_d) e_dwe[t+5+k] = 1'b1;
        else      e_iwe[t+5+k] = 1'b1;
      end
      for (int k = 1; k <= 12; k++) e_busy[t+k] = 1'b1;
      if (is_d) e_dtag[t+12] = 1'b1;
      else      e_itag[t+12] = 1'b1;
    end
    free_at = t + 13;
  endtask

  // Grant model: while idle, take a store, else an I miss, else a D miss.
  always @(posedge clk) begin
    if (rst_n === 1'b1 && cyc >= free_at) begin
      if (d_store)     sched_store(cyc, d_store_addr, d_store_data);
      else if (i_miss) sched_fill(cyc, 1'b0, i_miss_addr);
      else if (d_miss) sched_fill(cyc, 1'b1, d_miss_addr);
    end
    cyc++;
  end

  // Reset abandons everything scheduled from the current cycle on.
  always @(negedge rst_n) begin
    for (int c = cyc; c < NCYC; c++) begin
      e_en[c] = 0; e_wr[c] = 0; e_addr[c] = 0; e_wdat[c] = 0; e_ack[c] = 0;
      e_busy[c] = 0; e_iwe[c] = 0; e_dwe[c] = 0; e_itag[c] = 0; e_dtag[c] = 0;
      e_fadr[c] = 0;
    end
    free_at = 0;
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the timeline.
  int cc;
  always @(negedge clk) begin
    cc = cyc;
    if (cc < NCYC) begin
      chk("mem_en",    16'(mif.mem_en), 16'(e_en[cc]));
      chk("mem_wr",    16'(mif.mem_wr), 16'(e_wr[cc]));
      if (e_en[cc]) chk("mem_addr", mif.mem_addr, e_addr[cc]);
      if (e_wr[cc]) chk("mem_wdata", mif.mem_wdata, e_wdat[cc]);
      chk("store_ack", 16'(store_ack), 16'(e_ack[cc]));
      chk("busy",      16'(busy),      16'(e_busy[cc]));
      chk("i_data_we", 16'(i_data_we), 16'(e_iwe[cc]));
      chk("d_data_we", 16'(d_data_we), 16'(e_dwe[cc]));
      chk("i_tag_we",  16'(i_tag_we),  16'(e_itag[cc]));
      chk("d_tag_we",  16'(d_tag_we),  16'(e_dtag[cc]));
      if (e_iwe[cc] || e_dwe[cc]) begin
        chk("fill_addr", fill_addr, e_fadr[cc]);
        chk("fill_data", fill_data, e_fadr[cc] ^ 16'h5A3C);
      end
    end
  end

  task automatic to_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg(input int n);
    to_cyc(n);
    @(negedge clk);
  endtask

  int t0, t1;

  initial begin
    rst_n = 1'b0;
    i_miss = 0; d_miss = 0; d_store = 0; inject = 0;
    i_miss_addr = 0; d_miss_addr = 0; d_store_addr = 0; d_store_data = 0;

    // Reset state.
    @(negedge clk);
    chk("rst_busy",   16'(busy),       16'h0);
    chk("rst_mem_en", 16'(mif.mem_en), 16'h0);
    chk("rst_ack",    16'(store_ack),  16'h0);
    chk("rst_itag",   16'(i_tag_we),   16'h0);
    to_cyc(3);
    rst_n = 1'b1;
    to_cyc(5);

    // I miss at 0x1236: block 0x1230..0x123E.
    t0 = cyc;
    i_miss = 1; i_miss_addr = 16'h1236;
    at_neg(t0 + 1);
    chk("t1_first_rd", mif.mem_addr, 16'h1230);
    at_neg(t0 + 8);
    chk("t1_last_rd", mif.mem_addr, 16'h123E);
    to_cyc(t0 + 12);
    i_miss = 0;
    at_neg(t0 + 12);
    chk("t1_itag", 16'(i_tag_we), 16'h1);
    at_neg(t0 + 13);
    chk("t1_idle", 16'(busy), 16'h0);
    to_cyc(t0 + 15);

    // Simultaneous I and D misses: I first, then D.
    t0 = cyc;
    i_miss = 1; i_miss_addr = 16'h0040;
    d_miss = 1; d_miss_addr = 16'h8000;
    to_cyc(t0 + 12);
    i_miss = 0;
    at_neg(t0 + 14);
    chk("t2_d_first_rd", mif.mem_addr, 16'h8000);
    to_cyc(t0 + 25);
    d_miss = 0;
    at_neg(t0 + 25);
    chk("t2_dtag", 16'(d_tag_we), 16'h1);
    to_cyc(t0 + 27);

    // Store alongside a D miss: store first, fill starts two cycles later.
    t0 = cyc;
    d_store = 1; d_store_addr = 16'h0102; d_store_data = 16'hBEEF;
    d_miss = 1;  d_miss_addr = 16'h2468;
    at_neg(t0 + 1);
    chk("t3_ack",   16'(store_ack),  16'h1);
    chk("t3_wr",    16'(mif.mem_wr), 16'h1);
    chk("t3_addr",  mif.mem_addr,    16'h0102);
    chk("t3_wdata", mif.mem_wdata,   16'hBEEF);
    to_cyc(t0 + 2);
    d_store = 0;
    at_neg(t0 + 3);
    chk("t3_fill_rd", mif.mem_addr, 16'h2460);
    to_cyc(t0 + 14);
    d_miss = 0;
    to_cyc(t0 + 17);

    // Reset in cycle 7 of a fill, then a clean D fill.
    t0 = cyc;
    i_miss = 1; i_miss_addr = 16'h4A5C;
    to_cyc(t0 + 7);
    #1 rst_n = 1'b0;
    at_neg(t0 + 7);
    chk("t4_rst_busy", 16'(busy),       16'h0);
    chk("t4_rst_en",   16'(mif.mem_en), 16'h0);
    chk("t4_rst_iwe",  16'(i_data_we),  16'h0);
    i_miss = 0;
    to_cyc(t0 + 9);
    rst_n = 1'b1;
    to_cyc(t0 + 11);
    t1 = cyc;
    d_miss = 1; d_miss_addr = 16'h7FF8;
    to_cyc(t1 + 12);
    d_miss = 0;
    at_neg(t1 + 12);
    chk("t4_dtag",   16'(d_tag_we), 16'h1);
    chk("t4_last_f", fill_addr,     16'h7FFE);
    to_cyc(t1 + 15);

    // Miss dropped and address changed mid-fill: original block completes.
    t0 = cyc;
    i_miss = 1; i_miss_addr = 16'h3000;
    to_cyc(t0 + 4);
    i_miss = 0; i_miss_addr = 16'h5550;
    at_neg(t0 + 8);
    chk("t5_last_rd", mif.mem_addr, 16'h300E);
    at_neg(t0 + 12);
    chk("t5_itag", 16'(i_tag_we), 16'h1);
    to_cyc(t0 + 15);

    // Stray mem_valid while idle.
    t0 = cyc;
    inject = 1;
    at_neg(t0);
    chk("t6_iwe", 16'(i_data_we), 16'h0);
    chk("t6_dwe", 16'(d_data_we), 16'h0);
    chk("t6_tag", 16'(i_tag_we | d_tag_we), 16'h0);
    to_cyc(t0 + 2);
    inject = 0;
    to_cyc(t0 + 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
